// File: rtl/sensor_cond_pkg.sv
// Purpose : shared defaults and per-channel status type for the sensor conditioner.
// Latency : n/a (declarations only).
// Backpressure : n/a; the conditioner has no flow control and samples every cycle.
package sensor_cond_pkg;

    localparam int NUM_CH_DEF    = 3;
    localparam int DB_CYCLES_DEF = 16;
    localparam int STUCK_W_DEF   = 20;

    // One channel's conditioned outputs, bundled so the top level only has to
    // fan them out into the per-signal buses.
    typedef struct packed {
        logic clean;
        logic rise;
        logic fall;
        logic stuck;
    } ch_status_t;

endpackage

// File: rtl/sensor_conditioner_if.sv
// Purpose : bundles the raw sensor pins and the conditioned outputs of the conditioner.
// Latency : n/a (wires only).
// Backpressure : none; every signal is a level or a one-cycle strobe.
// Modports: master drives sensor_raw and observes the results; slave is the conditioner.
interface sensor_conditioner_if
    import sensor_cond_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF
);
    logic [NUM_CH-1:0] sensor_raw;
    logic [NUM_CH-1:0] sensor_clean;
    logic [NUM_CH-1:0] sensor_rise;
    logic [NUM_CH-1:0] sensor_fall;
    logic [NUM_CH-1:0] stuck;

    modport master (
        output sensor_raw,
        input  sensor_clean,
        input  sensor_rise,
        input  sensor_fall,
        input  stuck
    );

    modport slave (
        input  sensor_raw,
        output sensor_clean,
        output sensor_rise,
        output sensor_fall,
        output stuck
    );
endinterface

// File: rtl/sensor_debounce_ch.sv
// Purpose : one sensor channel: 2-flop synchroniser, debounce counter, edge strobes, optional stuck flag.
// Latency : DB_CYCLES+1 clock edges from the first sampling edge to a clean level change and strobe.
// Backpressure : none; the channel samples raw_i every cycle and its outputs cannot be stalled.
// Ports: clk, rst_n (async active-low), raw_i (asynchronous pin), status_o (clean/rise/fall/stuck).
// Optional feature: stuck counter compiled in when SENSOR_COND_STUCK_DET_EN is defined.
module sensor_debounce_ch
    import sensor_cond_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int STUCK_W   = STUCK_W_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       raw_i,
    output ch_status_t status_o
);

    localparam int             CW      = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(DB_CYCLES - 1);

    if (DB_CYCLES < 2) begin : g_bad_db
        $error("sensor_debounce_ch: DB_CYCLES must be at least 2");
    end
    if (STUCK_W < 1) begin : g_bad_stuck
        $error("sensor_debounce_ch: STUCK_W must be at least 1");
    end

    logic          s1_q, s2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          clean_q, clean_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic          flip;
    logic          stuck_w;

    // A flip happens on the edge where the disagreement has already persisted
    // DB_CYCLES-1 counted edges; any agreement before that restarts the count.
    always_comb begin
        cnt_d   = cnt_q;
        clean_d = clean_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        flip    = 1'b0;
        if (s2_q == clean_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            flip    = 1'b1;
            cnt_d   = '0;
            clean_d = s2_q;
            rise_d  = s2_q;
            fall_d  = ~s2_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            cnt_q   <= '0;
            clean_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            s1_q    <= raw_i;
            s2_q    <= s1_q;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

`ifdef SENSOR_COND_STUCK_DET_EN
    logic [STUCK_W-1:0] stk_q, stk_d;

    // Saturating idle counter; the flag is simply "counter at all-ones", so it
    // drops on the very edge the clean flip clears the counter.
    always_comb begin
        stk_d = stk_q;
        if (flip) begin
            stk_d = '0;
        end else if (!(&stk_q)) begin
            stk_d = stk_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stk_q <= '0;
        end else begin
            stk_q <= stk_d;
        end
    end

    assign stuck_w = &stk_q;
`else
    assign stuck_w = 1'b0;
`endif

    assign status_o.clean = clean_q;
    assign status_o.rise  = rise_q;
    assign status_o.fall  = fall_q;
    assign status_o.stuck = stuck_w;

endmodule

// File: rtl/sensor_conditioner.sv
// Purpose : conditions NUM_CH raw sensor pins into clean levels, rise/fall strobes and stuck flags.
// Latency : DB_CYCLES+1 clock edges from the first sampling edge to the clean level and strobe.
// Backpressure : none; inputs are sampled every cycle and outputs are unconditional registered levels/strobes.
// Ports: clk, rst_n (async active-low), bus (sensor_conditioner_if.slave: sensor_raw in;
//        sensor_clean, sensor_rise, sensor_fall, stuck out).
// Optional feature: SENSOR_COND_STUCK_DET_EN enables the per-channel stuck detector; otherwise stuck is 0.
module sensor_conditioner
    import sensor_cond_pkg::*;
#(
    parameter int NUM_CH    = NUM_CH_DEF,
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int STUCK_W   = STUCK_W_DEF
) (
    input logic                 clk,
    input logic                 rst_n,
    sensor_conditioner_if.slave bus
);

    ch_status_t        st [NUM_CH];
    logic [NUM_CH-1:0] clean_w, rise_w, fall_w, stuck_w;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        sensor_debounce_ch #(
            .DB_CYCLES (DB_CYCLES),
            .STUCK_W   (STUCK_W)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .raw_i    (bus.sensor_raw[i]),
            .status_o (st[i])
        );
    end

    always_comb begin
        clean_w = '0;
        rise_w  = '0;
        fall_w  = '0;
        stuck_w = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            clean_w[i] = st[i].clean;
            rise_w[i]  = st[i].rise;
            fall_w[i]  = st[i].fall;
            stuck_w[i] = st[i].stuck;
        end
    end

    assign bus.sensor_clean = clean_w;
    assign bus.sensor_rise  = rise_w;
    assign bus.sensor_fall  = fall_w;
    assign bus.stuck        = stuck_w;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Purpose : scoreboard bench for sensor_conditioner with DB_CYCLES=16 and directed stimulus.
// Latency : expects strobes DB_CYCLES+1 = 17 edges after the edge that first samples a change.
// Backpressure : none; a monitor compares every strobe cycle against the queued expectations.
module tb_sensor_conditioner;
    import sensor_cond_pkg::*;

`ifdef SENSOR_COND_STUCK_DET_EN
    localparam int         SW        = 6;
    localparam logic [2:0] STK_SAT   = 3'b111;
    localparam logic [2:0] STK_AFTER = 3'b110;
`else
    localparam int         SW        = 20;
    localparam logic [2:0] STK_SAT   = 3'b000;
    localparam logic [2:0] STK_AFTER = 3'b000;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   edge_cnt = 0;
    int   tests = 0;
    int   fails = 0;

    typedef struct {
        int         edge_n;
        logic [2:0] rise;
        logic [2:0] fall;
        logic [2:0] clean;
    } exp_t;

    exp_t sb[$];

    sensor_conditioner_if #(.NUM_CH(3)) bus ();

    sensor_conditioner #(
        .NUM_CH    (3),
        .DB_CYCLES (16),
        .STUCK_W   (SW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Returns at the negedge just before posedge number k.
    task automatic before_edge(input int k);
        while (edge_cnt < k - 1) @(negedge clk);
    endtask

    task automatic expect_ev(input int e, input logic [2:0] r, input logic [2:0] f, input logic [2:0] c);
        exp_t x;
        x.edge_n = e;
        x.rise   = r;
        x.fall   = f;
        x.clean  = c;
        sb.push_back(x);
    endtask

    // Monitor: every strobe cycle must match the oldest expected event; an
    // expected event whose edge has passed unseen is reported as missed.
    always @(negedge clk) begin
        if (sb.size() != 0 && edge_cnt > sb[0].edge_n) begin
            tests++;
            fails++;
            $display("FAIL missed_strobe: no strobe observed, expected one at edge %0d", sb[0].edge_n);
            void'(sb.pop_front());
        end
        if ((bus.sensor_rise | bus.sensor_fall) != 3'b000) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_strobe: rise=%b fall=%b at edge %0d, expected none",
                         bus.sensor_rise, bus.sensor_fall, edge_cnt);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("strobe_edge", edge_cnt, e.edge_n);
                chk("rise", {29'd0, bus.sensor_rise}, {29'd0, e.rise});
                chk("fall", {29'd0, bus.sensor_fall}, {29'd0, e.fall});
                chk("clean", {29'd0, bus.sensor_clean}, {29'd0, e.clean});
            end
        end
    end

    initial begin
        bus.sensor_raw = 3'b000;

        // Reset state, raw high during reset must not matter.
        before_edge(3);
        bus.sensor_raw = 3'b111;
        @(negedge clk);
        chk("rst_clean", {29'd0, bus.sensor_clean}, 32'd0);
        chk("rst_rise",  {29'd0, bus.sensor_rise},  32'd0);
        chk("rst_fall",  {29'd0, bus.sensor_fall},  32'd0);
        chk("rst_stuck", {29'd0, bus.stuck},        32'd0);
        bus.sensor_raw = 3'b000;
        before_edge(5);
        rst_n = 1'b1;

        // Clean step on channel 0: sampled at edge 10, clean at 27.
        before_edge(10);
        bus.sensor_raw = 3'b001;
        expect_ev(27, 3'b001, 3'b000, 3'b001);
        before_edge(27);
        chk("step_pre", {29'd0, bus.sensor_clean}, 32'd0);

        // Glitch on channel 1: 10 cycles high, never reaches the threshold.
        before_edge(40);
        bus.sensor_raw = 3'b011;
        before_edge(50);
        bus.sensor_raw = 3'b001;
        before_edge(70);
        chk("glitch_clean", {29'd0, bus.sensor_clean}, 32'd1);

        // Bounce on channel 2: 21 toggles every 3 cycles, ending high at edge 140.
        for (int i = 0; i < 21; i++) begin
            before_edge(80 + 3 * i);
            bus.sensor_raw[2] = ~bus.sensor_raw[2];
        end
        expect_ev(157, 3'b100, 3'b000, 3'b101);
        before_edge(157);
        chk("bounce_pre", {29'd0, bus.sensor_clean}, 32'd1);
        before_edge(180);
        bus.sensor_raw = 3'b001;
        expect_ev(197, 3'b000, 3'b100, 3'b001);

        // Bring channel 0 back to 0, then all three rise together and fall together.
        before_edge(210);
        bus.sensor_raw = 3'b000;
        expect_ev(227, 3'b000, 3'b001, 3'b000);
        before_edge(250);
        bus.sensor_raw = 3'b111;
        expect_ev(267, 3'b111, 3'b000, 3'b111);
        before_edge(290);
        bus.sensor_raw = 3'b000;
        expect_ev(307, 3'b000, 3'b111, 3'b000);

        // Reset mid-count: raw high from edge 330, reset before edge 338.
        before_edge(330);
        bus.sensor_raw = 3'b111;
        before_edge(338);
        chk("midrst_pre", {29'd0, bus.sensor_clean}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst_clean", {29'd0, bus.sensor_clean}, 32'd0);
        before_edge(341);
        rst_n = 1'b1;
        expect_ev(358, 3'b111, 3'b000, 3'b111);
        before_edge(358);
        chk("midrst_hold", {29'd0, bus.sensor_clean}, 32'd0);

        // Idle after the flip at 358: stuck counters saturate 63 edges later.
        before_edge(421);
        chk("stuck_before_sat", {29'd0, bus.stuck}, 32'd0);
        before_edge(422);
        chk("stuck_sat", {29'd0, bus.stuck}, {29'd0, STK_SAT});
        before_edge(430);
        bus.sensor_raw = 3'b110;
        expect_ev(447, 3'b000, 3'b001, 3'b110);
        before_edge(447);
        chk("stuck_pre_clear", {29'd0, bus.stuck}, {29'd0, STK_SAT});
        before_edge(448);
        chk("stuck_clear", {29'd0, bus.stuck}, {29'd0, STK_AFTER});

        before_edge(470);
        chk("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
